// File: rtl/fir_fifo_sc.sv
// Single-clock FIFO for signed FIR samples with registered read data.
// Optional sticky overflow/underflow outputs are enabled by defining FIR_FIFO_ERR_EN.
module fir_fifo_sc #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wen,
    input  logic signed [WIDTH-1:0] din,
    output logic                    full,
    input  logic                    ren,
    output logic signed [WIDTH-1:0] dout,
`ifdef FIR_FIFO_ERR_EN
    output logic                    overflow,
    output logic                    underflow,
`endif
    output logic                    empty
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    wr_acc;
    logic                    rd_acc;

    // Flags decode the registered pointers; the MSB distinguishes full from empty.
    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
        wr_acc = wen && !full;
        rd_acc = ren && !empty;
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
        end
    end

    // dout only moves on an accepted read and otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            dout   <= '0;
        end else if (rd_acc) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            dout   <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

`ifdef FIR_FIFO_ERR_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && full) begin
                overflow <= 1'b1;
            end
            if (ren && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_fifo_sc.sv
// Scoreboard bench for fir_fifo_sc: stimulus pushes expected samples, a monitor pops them on accepted reads.
module tb_fir_fifo_sc;

    localparam int W = 16;
    localparam int D = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                wen = 1'b0;
    logic                ren = 1'b0;
    logic signed [W-1:0] din = '0;
    logic                full;
    logic                empty;
    logic signed [W-1:0] dout;
`ifdef FIR_FIFO_ERR_EN
    logic                overflow;
    logic                underflow;
`endif

    int                  checks = 0;
    int                  errors = 0;
    int                  occ = 0;
    logic signed [W-1:0] sb[$];
    logic signed [W-1:0] last_rd = '0;
    bit                  ovf_exp = 1'b0;
    bit                  unf_exp = 1'b0;

    fir_fifo_sc dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .din      (din),
        .full     (full),
        .ren      (ren),
        .dout     (dout),
`ifdef FIR_FIFO_ERR_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .empty    (empty)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    // val(0) = 16'sh3524 = 13604; later entries wrap into negative values.
    function automatic logic signed [W-1:0] val(input int i);
        return W'(13604 + i * 3361);
    endfunction

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input bit w, input bit r, input logic signed [W-1:0] d);
        bit wacc;
        bit racc;
        wen  = w;
        ren  = r;
        din  = d;
        wacc = w && (occ < D);
        racc = r && (occ > 0);
        if (w && occ == D) ovf_exp = 1'b1;
        if (r && occ == 0) unf_exp = 1'b1;
        if (wacc) sb.push_back(d);
        @(posedge clk);
        #1;
        occ = occ + int'(wacc) - int'(racc);
        wen = 1'b0;
        ren = 1'b0;
        chk("empty", int'(empty), int'(occ == 0));
        chk("full", int'(full), int'(occ == D));
`ifdef FIR_FIFO_ERR_EN
        chk("overflow", int'(overflow), int'(ovf_exp));
        chk("underflow", int'(underflow), int'(unf_exp));
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_rst();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_empty", int'(empty), 1);
        chk("rst_async_full", int'(full), 0);
        chk("rst_async_dout", int'(dout), 0);
`ifdef FIR_FIFO_ERR_EN
        chk("rst_async_ovf", int'(overflow), 0);
        chk("rst_async_unf", int'(underflow), 0);
`endif
        sb.delete();
        occ     = 0;
        ovf_exp = 1'b0;
        unf_exp = 1'b0;
        last_rd = '0;
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every accepted read must present the oldest queued sample.
    always @(posedge clk) begin
        logic signed [W-1:0] e;
        if (!rst && ren && !empty) begin
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_nodata: got %0d expected no read", int'(dout));
            end else begin
                e = sb.pop_front();
                chk("dout", int'(dout), int'(e));
                last_rd = e;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_dout", int'(dout), 0);
`ifdef FIR_FIFO_ERR_EN
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_unf", int'(underflow), 0);
`endif
        rst = 1'b0;

        // Fill slowly, then try a 65th write
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, 1'b0, val(i));
            if (i == D - 2) chk("full_after_63", int'(full), 0);
            if (i == D - 1) chk("full_after_64", int'(full), 1);
            repeat (3) cyc(1'b0, 1'b0, '0);
        end
        cyc(1'b1, 1'b0, 16'sh7fff);

        // Drain slowly and check order
        for (int i = 0; i < D; i++) begin
            cyc(1'b0, 1'b1, '0);
            repeat (3) cyc(1'b0, 1'b0, '0);
            if (i == 0) chk("first_rd", int'(dout), 13604);
        end
        chk("drain_empty", int'(empty), 1);
        cyc(1'b0, 1'b1, '0);
        chk("dout_hold_empty_rd", int'(dout), int'(last_rd));

        // wen+ren while empty: write only
        cyc(1'b1, 1'b1, 16'sh1234);
        chk("simul_empty_hold", int'(dout), int'(last_rd));
        chk("simul_empty_notempty", int'(empty), 0);
        cyc(1'b0, 1'b1, '0);
        chk("simul_empty_rd", int'(dout), 4660);

        // Back-to-back fill across pointer rollover, then wen+ren while full
        for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, val(100 + i));
        cyc(1'b1, 1'b1, 16'sh5555);
        chk("simul_full_cleared", int'(full), 0);
        repeat (D - 1) cyc(1'b0, 1'b1, '0);

        // Concurrency: preload 16, read down to 5, same-edge wen+ren, interleave
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, val(200 + i));
        repeat (11) cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, val(216));
        for (int j = 0; j < 7; j++) begin
            cyc(1'b1, 1'b0, val(217 + j));
            if (j < 4) cyc(1'b0, 1'b1, '0);
        end
        repeat (8) cyc(1'b0, 1'b1, '0);

        // Mid-operation reset discards queued data
        cyc(1'b1, 1'b0, val(300));
        cyc(1'b1, 1'b0, val(301));
        cyc(1'b1, 1'b0, val(302));
        pulse_rst();
        cyc(1'b1, 1'b0, 16'sh0abc);
        cyc(1'b1, 1'b0, 16'sh0def);
        cyc(1'b0, 1'b1, '0);
        chk("post_rst_first_rd", int'(dout), 2748);
        cyc(1'b0, 1'b1, '0);
        chk("post_rst_second_rd", int'(dout), 3567);
        repeat (2) cyc(1'b0, 1'b0, '0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
